ps2_keycode: RTL and testbench

PS/2 keyboard front end that produces the 8-bit USB HID usage `keycode` consumed by the on-screen sprite-motion logic (W 0x1A, S 0x16, A 0x04, D 0x07). It gives the FPGA a local keyboard path with the same keycode contract as the USB/MicroBlaze path. It deserialises PS/2 device-to-host frames, strips make/break/extended prefixes, and translates a fixed subset of set-2 scan codes to HID usages. It holds the last pressed key until that key is released.

---
 rtl/ps2_pkg.sv | 60 ++++++
 rtl/ps2_rx.sv | 159 +++++++++++++++
 rtl/ps2_keycode.sv | 99 +++++++++
 tb/tb_ps2_keycode.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, prefix codes, HID usages and the scan-code translation for
// the PS/2 keyboard front end.
package ps2_pkg;

  // Receive frame FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Set-2 prefix bytes.
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // HID usages produced by the translation table.
  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_ESC   = 8'h29;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_UP    = 8'h52;

  // Translate (extended flag, scan code) to {mapped, hid usage}.
  // Unmapped codes return mapped=0 and usage 0x00.
  function automatic logic [8:0] ps2_to_hid(input logic ext, input logic [7:0] code);
    logic [8:0] res;
    res = {1'b0, HID_NONE};
    if (!ext) begin
      case (code)
        8'h1D:   res = {1'b1, HID_W};
        8'h1B:   res = {1'b1, HID_S};
        8'h1C:   res = {1'b1, HID_A};
        8'h23:   res = {1'b1, HID_D};
        8'h29:   res = {1'b1, HID_SPACE};
        8'h5A:   res = {1'b1, HID_ENTER};
        8'h76:   res = {1'b1, HID_ESC};
        default: res = {1'b0, HID_NONE};
      endcase
    end else begin
      case (code)
        8'h75:   res = {1'b1, HID_UP};
        8'h72:   res = {1'b1, HID_DOWN};
        8'h6B:   res = {1'b1, HID_LEFT};
        8'h74:   res = {1'b1, HID_RIGHT};
        default: res = {1'b0, HID_NONE};
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver: pin synchronisers, clock glitch filter,
// falling-edge strobe, 11-bit frame FSM and inter-edge timeout.
//
// state  | meaning
// IDLE   | waiting for a start bit (data=0 on a falling edge)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking parity and the stop bit, then releasing the byte
//
// byte_valid_o / frame_err_o are combinational strobes in the cycle the
// stop bit (or timeout) is evaluated; the consumer registers them, which
// keeps the pin-to-output latency at FILTER_CYCLES + 4.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_TC = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TO_TC   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_dly_q;
  logic          fall_q;
  logic          data_s;

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout;

  assign data_s = data_sync_q[1];
  assign byte_o = shift_q;

  // Filter: the filtered clock only follows the synchronised pin after
  // FILTER_CYCLES consecutive samples at the new level.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_TC) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  // Synchronisers, filter state and edge register; idle line is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      filt_dly_q  <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_dly_q  <= filt_q;
      fall_q      <= filt_dly_q & ~filt_q;
    end
  end

  // Frame FSM next state, timeout counter and byte/error strobes.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;

    if (fall_q || state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_TC) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
    // A falling edge in the terminal cycle wins over the timeout, so an
    // error strobe and a byte strobe can never coincide.
    timeout = (state_q != IDLE) && !fall_q && (to_cnt_q == TO_TC);

    case (state_q)
      IDLE: begin
        if (fall_q && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall_q) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_q) begin
          par_d   = data_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          state_d = IDLE;
          if ((^{shift_q, par_q}) && data_s) begin
            byte_valid_o = 1'b1;
          end else begin
            frame_err_o = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d     = IDLE;
      frame_err_o = 1'b1;
    end
  end

  // Frame FSM registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard to HID keycode front end: strips E0/F0/E1 prefixes,
// translates a fixed set of scan codes and holds the last pressed key
// until that same key is released.
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_err;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [7:0] key_q, key_d;
  logic       kv_q, kv_d;
  logic       fe_q, fe_d;
  logic [8:0] lookup;

  ps2_rx #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_valid_o(byte_valid),
    .byte_o      (rx_byte),
    .frame_err_o (rx_err)
  );

  assign lookup = ps2_to_hid(ext_q, rx_byte);

  // Prefix tracking, translation and held-key update.
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    key_d = key_q;
    kv_d  = 1'b0;
    fe_d  = 1'b0;
    if (rx_err) begin
      // A broken frame may have been a prefix; forget any partial sequence.
      fe_d  = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      case (rx_byte)
        PS2_EXT:   ext_d = 1'b1;
        PS2_BRK:   brk_d = 1'b1;
        PS2_PAUSE: ;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (lookup[8]) begin
            if (brk_q) begin
              if (lookup[7:0] == key_q) key_d = HID_NONE;
            end else begin
              key_d = lookup[7:0];
              kv_d  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Output and flag registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      key_q <= HID_NONE;
      kv_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      key_q <= key_d;
      kv_q  <= kv_d;
      fe_q  <= fe_d;
    end
  end

  assign keycode   = key_q;
  assign key_valid = kv_q;
  assign frame_err = fe_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Directed bench for ps2_keycode: drives PS/2 frames on the pins and checks
// keycode, pulse counts and pin-to-output latency against hand-computed values.
module tb_ps2_keycode;

  localparam int FILT = 8;
  localparam int TOUT = 2000;
  localparam int LAT  = FILT + 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int kv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int kv_cyc = 0, fe_cyc = 0, last_fall = 0;
  int kv0, fe0;
  logic [15:0] fr;

  ps2_keycode #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TOUT)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keycode  (keycode),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge Clk) begin
    if (key_valid) begin kv_cnt++; kv_cyc = cyc; end
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (key_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clk(15);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    wait_clk(30);
    ps2_clk = 1'b1;
    wait_clk(15);
  endtask

  // Send the low n bits of v, LSB first.
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) ps2_bit(v[i]);
  endtask

  function automatic logic [15:0] frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {5'b0, 1'b1, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b, 1'b0), 11);
    wait_clk(20);
  endtask

  initial begin
    Reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_clk(5);
    check("rst_keycode", {24'b0, keycode}, 32'h00);
    check("rst_kv", {31'b0, key_valid}, 32'h0);
    check("rst_fe", {31'b0, frame_err}, 32'h0);
    Reset = 1'b0;
    wait_clk(10);

    // A make, release after a gap.
    send_byte(8'h1C);
    check("a_make_key", {24'b0, keycode}, 32'h04);
    check("a_make_kv", kv_cnt, 1);
    check("a_make_lat", kv_cyc - last_fall + 0, 32'd0 + LAT - (last_fall - last_fall));
    wait_clk(200);
    send_byte(8'hF0);
    check("a_brk_mid", {24'b0, keycode}, 32'h04);
    send_byte(8'h1C);
    check("a_brk_key", {24'b0, keycode}, 32'h00);
    check("a_brk_kv", kv_cnt, 1);

    // Extended up arrow.
    kv0 = kv_cnt;
    send_byte(8'hE0); send_byte(8'h75);
    check("up_make", {24'b0, keycode}, 32'h52);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("up_brk", {24'b0, keycode}, 32'h00);
    check("up_kv", kv_cnt - kv0, 1);

    // W, then D, then W released: D stays held.
    kv0 = kv_cnt;
    send_byte(8'h1D);
    check("w_make", {24'b0, keycode}, 32'h1A);
    send_byte(8'h23);
    check("d_make", {24'b0, keycode}, 32'h07);
    send_byte(8'hF0); send_byte(8'h1D);
    check("w_brk_other", {24'b0, keycode}, 32'h07);
    check("wd_kv", kv_cnt - kv0, 2);
    send_byte(8'hF0); send_byte(8'h23);
    check("d_brk", {24'b0, keycode}, 32'h00);

    // Parity error, then a good frame.
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_bits(frame(8'h1C, 1'b1), 11);
    wait_clk(20);
    check("par_fe", fe_cnt - fe0, 1);
    check("par_lat", fe_cyc - last_fall, LAT);
    check("par_key", {24'b0, keycode}, 32'h00);
    check("par_kv", kv_cnt - kv0, 0);
    send_byte(8'h1C);
    check("par_recover", {24'b0, keycode}, 32'h04);
    send_byte(8'hF0); send_byte(8'h1C);

    // Timeout after start + 4 data bits, then a good S frame.
    fe0 = fe_cnt; kv0 = kv_cnt;
    send_bits(frame(8'h1B, 1'b0), 5);
    wait_clk(TOUT + 50);
    check("to_fe", fe_cnt - fe0, 1);
    check("to_kv", kv_cnt - kv0, 0);
    send_byte(8'h1B);
    check("to_recover", {24'b0, keycode}, 32'h16);
    send_byte(8'hF0); send_byte(8'h1B);
    check("s_brk", {24'b0, keycode}, 32'h00);

    // Short clock glitches with data low must not start a frame.
    fe0 = fe_cnt; kv0 = kv_cnt;
    ps2_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0; wait_clk(3);
      ps2_clk = 1'b1; wait_clk(20);
    end
    ps2_data = 1'b1;
    wait_clk(TOUT + 100);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_kv", kv_cnt - kv0, 0);

    // Reset in the middle of a W frame while A is held.
    send_byte(8'h1C);
    check("pre_rst_key", {24'b0, keycode}, 32'h04);
    kv0 = kv_cnt;
    fr = frame(8'h1D, 1'b0);
    send_bits(fr, 5);
    Reset = 1'b1;
    wait_clk(3);
    check("mid_rst_key", {24'b0, keycode}, 32'h00);
    check("mid_rst_kv", {31'b0, key_valid}, 32'h0);
    check("mid_rst_fe", {31'b0, frame_err}, 32'h0);
    Reset = 1'b0;
    wait_clk(5);
    send_bits(fr >> 5, 6);
    wait_clk(TOUT + 100);
    check("post_rst_key", {24'b0, keycode}, 32'h00);
    check("post_rst_kv", kv_cnt - kv0, 0);

    check("exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
